// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end and IF/ID stage buffer:
// fetch state encoding, PC constants and IF/ID field layout.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        START,
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_e;

    localparam int unsigned IF_PC_WIDTH    = 16;
    localparam int unsigned IF_INSTR_WIDTH = 16;
    localparam int unsigned IF_PC_STEP     = 2;
    localparam logic [IF_PC_WIDTH-1:0] IF_RESET_PC = 16'h0000;

    // IF/ID word: {pc_plus2, instr}
    localparam int unsigned IFID_WIDTH     = 32;
    localparam int unsigned IFID_PC_LSB    = 16;
    localparam int unsigned IFID_INSTR_LSB = 0;

endpackage

// File: rtl/register.sv
// Generic pipeline register with write enable and synchronous flush to zero.
module register #(
    parameter int unsigned SIZE = 32
) (
    input  logic [SIZE-1:0] in,
    input  logic            writeEnable,
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    output logic [SIZE-1:0] out
);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            out <= '0;
        else if (flush)
            out <= '0;
        else if (writeEnable)
            out <= in;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the imem req/ack handshake and
// feeds the IF/ID buffer, absorbing ID stalls and branch redirects.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned          PC_WIDTH    = IF_PC_WIDTH,
    parameter int unsigned          INSTR_WIDTH = IF_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = IF_RESET_PC,
    parameter int unsigned          PC_STEP     = IF_PC_STEP
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic [PC_WIDTH-1:0]    ifid_pc_plus2,
    output logic [INSTR_WIDTH-1:0] ifid_instr,
    output logic [PC_WIDTH-1:0]    fetch_pc
);

    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

    fetch_state_e           state, state_next;
    logic [PC_WIDTH-1:0]    pc_next, target_pc, target_next, pc_plus_step;
    logic                   hold_we, hold_flush, use_live;
    logic [IFID_WIDTH-1:0]  hold_in, hold_out;

    assign pc_plus_step = fetch_pc + STEP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= START;
            fetch_pc  <= RESET_PC;
            target_pc <= '0;
        end else begin
            state     <= state_next;
            fetch_pc  <= pc_next;
            target_pc <= target_next;
        end
    end

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_next  = state;
        pc_next     = fetch_pc;
        target_next = redirect ? redirect_pc : target_pc;
        imem_req    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = redirect;
        hold_we     = 1'b0;
        hold_flush  = 1'b0;
        use_live    = 1'b0;

        unique case (state)
            START: begin
                if (redirect) pc_next = redirect_pc;
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    // An unanswered request cannot be dropped, so its ack is drained first.
                    if (imem_ack) pc_next    = redirect_pc;
                    else          state_next = DRAIN;
                end else if (imem_ack) begin
                    pc_next = pc_plus_step;
                    if (stall) begin
                        hold_we    = 1'b1;
                        state_next = HOLD;
                    end else begin
                        ifid_write = 1'b1;
                        use_live   = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    hold_flush = 1'b1;
                    pc_next    = redirect_pc;
                    state_next = FETCH;
                end else if (!stall) begin
                    ifid_write = 1'b1;
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    pc_next    = target_next;
                    state_next = FETCH;
                end
            end
            default: state_next = START;
        endcase
    end

    assign hold_in[IFID_PC_LSB +: PC_WIDTH]       = pc_plus_step;
    assign hold_in[IFID_INSTR_LSB +: INSTR_WIDTH] = imem_rdata;

    register #(.SIZE(IFID_WIDTH)) u_hold (
        .in          (hold_in),
        .writeEnable (hold_we),
        .clk         (clk),
        .rst         (rst),
        .flush       (hold_flush),
        .out         (hold_out)
    );

    assign imem_addr     = fetch_pc;
    assign ifid_pc_plus2 = use_live ? pc_plus_step : hold_out[IFID_PC_LSB +: PC_WIDTH];
    assign ifid_instr    = use_live ? imem_rdata   : hold_out[IFID_INSTR_LSB +: INSTR_WIDTH];

endmodule
